// File: rtl/mv_sched_pkg.sv
// mv_sched_pkg: shared types and constants for the tiled matrix-vector
// sequencer (mv_tile_sched) and its lane accumulator (mv_lane_acc).
//   - sched_state_e : sequencer FSM states
//   - LANES/DW      : 16 lanes of 16-bit signed data per tile row/vector
//   - TILE_BITS     : packed width of one vector tile / psum / output tile
//   - MAT_BITS      : packed width of one 16x16 matrix tile
//   - lane_get()    : extracts lane k, lane 0 being the most significant slice
package mv_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_ACC   = 3'd4,
      ST_WRITE = 3'd5,
      ST_DONE  = 3'd6
   } sched_state_e;

   localparam int LANES     = 16;
   localparam int DW        = 16;
   localparam int TILE_BITS = 256;
   localparam int MAT_BITS  = 4096;

   // Lane k occupies bits [TILE_BITS-1-DW*k -: DW].
   function automatic logic [DW-1:0] lane_get(input logic [TILE_BITS-1:0] v, input int k);
      return v[TILE_BITS-1-DW*k -: DW];
   endfunction

endpackage

// File: rtl/mv_tile_sched_if.sv
// mv_tile_sched_if: bundles every non-clock/reset signal of mv_tile_sched.
//   control : start (in), busy, done (out)
//   operands: vec_addr, mat_addr, rd_req (out); vec_rdata, mat_rdata (in, 1-cycle latency)
//   engine  : eng_en, eng_ai, eng_matrix (out); eng_psum, eng_finish (in)
//   output  : out_we, out_addr, out_data (out)
// modport master = the sequencer's view, modport slave = its environment.
interface mv_tile_sched_if
   import mv_sched_pkg::*;
#(
   parameter int TILES = 4,
   parameter int TW    = (TILES > 1) ? $clog2(TILES) : 1
);
   logic                  start;
   logic                  busy;
   logic                  done;
   logic [TW-1:0]         vec_addr;
   logic [2*TW-1:0]       mat_addr;
   logic                  rd_req;
   logic [TILE_BITS-1:0]  vec_rdata;
   logic [MAT_BITS-1:0]   mat_rdata;
   logic                  eng_en;
   logic [TILE_BITS-1:0]  eng_ai;
   logic [MAT_BITS-1:0]   eng_matrix;
   logic [TILE_BITS-1:0]  eng_psum;
   logic                  eng_finish;
   logic                  out_we;
   logic [TW-1:0]         out_addr;
   logic [TILE_BITS-1:0]  out_data;

   modport master (
      input  start, vec_rdata, mat_rdata, eng_psum, eng_finish,
      output busy, done, vec_addr, mat_addr, rd_req, eng_en, eng_ai, eng_matrix,
             out_we, out_addr, out_data
   );

   modport slave (
      output start, vec_rdata, mat_rdata, eng_psum, eng_finish,
      input  busy, done, vec_addr, mat_addr, rd_req, eng_en, eng_ai, eng_matrix,
             out_we, out_addr, out_data
   );
endinterface

// File: rtl/mv_lane_acc.sv
// mv_lane_acc: 16-lane signed 16-bit accumulator.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear all lanes (wins over add_en)
//   add_en   : acc <= acc + psum, lane-wise
//   psum     : addend, lane order as lane_get()
//   acc      : registered accumulator
//   sum      : combinational acc + psum, lets the caller capture the final
//              total in the same edge that performs the last add
// Build option MV_SCHED_SAT_ACC_EN: lane adds saturate to [-32768, 32767];
// otherwise they wrap modulo 2^16.
module mv_lane_acc
   import mv_sched_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 add_en,
   input  logic [TILE_BITS-1:0] psum,
   output logic [TILE_BITS-1:0] acc,
   output logic [TILE_BITS-1:0] sum
);

   logic [TILE_BITS-1:0] acc_r;
   logic [TILE_BITS-1:0] sum_s;

   function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MV_SCHED_SAT_ACC_EN
      logic [DW:0] s;
      s = {a[DW-1], a} + {b[DW-1], b};
      // Sign of the 17-bit sum differs from bit 15 only on overflow.
      if (s[DW] != s[DW-1]) begin
         lane_add = s[DW] ? 16'h8000 : 16'h7FFF;
      end else begin
         lane_add = s[DW-1:0];
      end
`else
      lane_add = a + b;
`endif
   endfunction

   // Lane-wise next total.
   always_comb begin
      sum_s = {TILE_BITS{1'b0}};
      for (int k = 0; k < LANES; k++) begin
         sum_s[TILE_BITS-1-DW*k -: DW] = lane_add(lane_get(acc_r, k), lane_get(psum, k));
      end
   end

   // Accumulator register.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r <= {TILE_BITS{1'b0}};
      end else if (clr) begin
         acc_r <= {TILE_BITS{1'b0}};
      end else if (add_en) begin
         acc_r <= sum_s;
      end else begin
         acc_r <= acc_r;
      end
   end

   assign acc = acc_r;
   assign sum = sum_s;

endmodule

// File: rtl/mv_tile_sched.sv
// mv_tile_sched: runs an N x N (N = 16*TILES) signed 16-bit matrix-vector
// product on one 16x16 dot-product engine by tiling. For each row tile i it
// walks column tiles j: FETCH (read strobe) -> LOAD (capture operands) ->
// RUN (engine enabled until eng_finish) -> ACC (add psum). After the last j
// the row total is written out (WRITE); after the last i, DONE pulses.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mv_tile_sched_if.master (start/busy/done, operand reads,
//              engine drive/results, output writes)
// All outputs are registered and decoded from the next state, so each
// strobe is aligned with the state it belongs to.
// Build option MV_SCHED_SAT_ACC_EN: saturating accumulation (in mv_lane_acc).
module mv_tile_sched
   import mv_sched_pkg::*;
#(
   parameter int TILES = 4,
   parameter int TW    = (TILES > 1) ? $clog2(TILES) : 1
)
(
   input  logic             clk,
   input  logic             rst,
   mv_tile_sched_if.master  bus
);

   localparam logic [TW-1:0] LAST_IDX = TW'(TILES - 1);

   sched_state_e          state_r, state_nxt_s;
   logic [TW-1:0]         i_r, j_r, i_nxt_s, j_nxt_s;
   logic                  acc_clr_s, acc_add_s;
   logic [TILE_BITS-1:0]  psum_r;
   logic [TILE_BITS-1:0]  acc_s, acc_sum_s;

   logic                  busy_r, done_r, rd_req_r, eng_en_r, out_we_r;
   logic [TW-1:0]         vec_addr_r, out_addr_r;
   logic [2*TW-1:0]       mat_addr_r;
   logic [TILE_BITS-1:0]  eng_ai_r, out_data_r;
   logic [MAT_BITS-1:0]   eng_matrix_r;

   // Next-state, tile-index and accumulator-control decode.
   always_comb begin
      state_nxt_s = state_r;
      i_nxt_s     = i_r;
      j_nxt_s     = j_r;
      acc_clr_s   = 1'b0;
      acc_add_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt_s = ST_FETCH;
               i_nxt_s     = {TW{1'b0}};
               j_nxt_s     = {TW{1'b0}};
               acc_clr_s   = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH: state_nxt_s = ST_LOAD;
         ST_LOAD:  state_nxt_s = ST_RUN;
         ST_RUN: begin
            if (bus.eng_finish) begin
               state_nxt_s = ST_ACC;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_ACC: begin
            acc_add_s = 1'b1;
            if (j_r == LAST_IDX) begin
               state_nxt_s = ST_WRITE;
            end else begin
               j_nxt_s     = j_r + 1'b1;
               state_nxt_s = ST_FETCH;
            end
         end
         ST_WRITE: begin
            acc_clr_s = 1'b1;
            j_nxt_s   = {TW{1'b0}};
            if (i_r == LAST_IDX) begin
               state_nxt_s = ST_DONE;
            end else begin
               i_nxt_s     = i_r + 1'b1;
               state_nxt_s = ST_FETCH;
            end
         end
         ST_DONE:  state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // State and tile-index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         i_r     <= {TW{1'b0}};
         j_r     <= {TW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         i_r     <= i_nxt_s;
         j_r     <= j_nxt_s;
      end
   end

   // Engine result is captured in the same cycle finish is seen in RUN;
   // finish in any other state is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         psum_r <= {TILE_BITS{1'b0}};
      end else if ((state_r == ST_RUN) && bus.eng_finish) begin
         psum_r <= bus.eng_psum;
      end else begin
         psum_r <= psum_r;
      end
   end

   mv_lane_acc u_acc (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr_s),
      .add_en (acc_add_s),
      .psum   (psum_r),
      .acc    (acc_s),
      .sum    (acc_sum_s)
   );

   // Registered outputs, decoded from the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         rd_req_r     <= 1'b0;
         eng_en_r     <= 1'b0;
         out_we_r     <= 1'b0;
         vec_addr_r   <= {TW{1'b0}};
         mat_addr_r   <= {(2*TW){1'b0}};
         out_addr_r   <= {TW{1'b0}};
         eng_ai_r     <= {TILE_BITS{1'b0}};
         eng_matrix_r <= {MAT_BITS{1'b0}};
         out_data_r   <= {TILE_BITS{1'b0}};
      end else begin
         busy_r   <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
         done_r   <= (state_nxt_s == ST_DONE);
         rd_req_r <= (state_nxt_s == ST_FETCH);
         eng_en_r <= (state_nxt_s == ST_RUN);
         out_we_r <= (state_nxt_s == ST_WRITE);
         if (state_nxt_s == ST_FETCH) begin
            vec_addr_r <= j_nxt_s;
            mat_addr_r <= {i_nxt_s, j_nxt_s};
         end else begin
            vec_addr_r <= vec_addr_r;
            mat_addr_r <= mat_addr_r;
         end
         // Read data is valid in LOAD (one cycle after the strobe).
         if (state_r == ST_LOAD) begin
            eng_ai_r     <= bus.vec_rdata;
            eng_matrix_r <= bus.mat_rdata;
         end else begin
            eng_ai_r     <= eng_ai_r;
            eng_matrix_r <= eng_matrix_r;
         end
         // Entering WRITE only from ACC: take the post-add total directly.
         if (state_nxt_s == ST_WRITE) begin
            out_addr_r <= i_r;
            out_data_r <= acc_sum_s;
         end else begin
            out_addr_r <= out_addr_r;
            out_data_r <= out_data_r;
         end
      end
   end

   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.rd_req     = rd_req_r;
   assign bus.eng_en     = eng_en_r;
   assign bus.out_we     = out_we_r;
   assign bus.vec_addr   = vec_addr_r;
   assign bus.mat_addr   = mat_addr_r;
   assign bus.out_addr   = out_addr_r;
   assign bus.eng_ai     = eng_ai_r;
   assign bus.eng_matrix = eng_matrix_r;
   assign bus.out_data   = out_data_r;

endmodule

// File: tb/tb_mv_tile_sched.sv
// tb_mv_tile_sched: self-checking bench for mv_tile_sched (TILES=4, 64x64).
// Models the operand buffers, a dot-product engine with configurable finish
// delay, and computes expected outputs from the full matrix and vector.
// Honours MV_SCHED_SAT_ACC_EN for the expected accumulation behaviour.
module tb_mv_tile_sched;

   localparam int T = 4;
   localparam int N = 16 * T;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mv_tile_sched_if #(.TILES(T), .TW(2)) bus ();

   mv_tile_sched #(.TILES(T), .TW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   logic signed [15:0] mm [N][N];
   logic signed [15:0] vv [N];
   logic [15:0]        expo [N];

   int tests_run = 0;
   int tests_failed = 0;

   // engine model state
   int e_delay = 3;
   int e_cnt = 0;
   bit spur_en = 1'b0;

   // run observations
   logic [255:0] got [T];
   int wr_cnt, rd_cnt, done_cnt, done_cyc, gap_bad, busy_bad, runs;
   bit timed_out;
   logic ab_en, ab_busy, ab_we;
   int ab_post_we, ab_post_done, ab_post_busy;

   function automatic logic [255:0] pack_vec(input int j);
      logic [255:0] r;
      for (int k = 0; k < 16; k++) r[255-16*k -: 16] = vv[16*j+k];
      return r;
   endfunction

   function automatic logic [4095:0] pack_mat(input int i, input int j);
      logic [4095:0] r;
      for (int a = 0; a < 16; a++)
         for (int c = 0; c < 16; c++)
            r[4095-256*a-16*c -: 16] = mm[16*i+a][16*j+c];
      return r;
   endfunction

   function automatic logic [255:0] eng_f(input logic [255:0] ai, input logic [4095:0] m);
      logic [255:0] r;
      int s;
      for (int a = 0; a < 16; a++) begin
         s = 0;
         for (int c = 0; c < 16; c++)
            s += int'($signed(m[4095-256*a-16*c -: 16])) * int'($signed(ai[255-16*c -: 16]));
         r[255-16*a -: 16] = s[15:0];
      end
      return r;
   endfunction

   // 1-cycle-latency operand buffers
   always @(posedge clk) begin
      if (bus.rd_req) begin
         bus.vec_rdata <= pack_vec(int'(bus.vec_addr));
         bus.mat_rdata <= pack_mat(int'(bus.mat_addr[3:2]), int'(bus.mat_addr[1:0]));
      end
   end

   // engine: finish in the e_delay-th cycle of eng_en high
   always @(posedge clk) begin
      if (!bus.eng_en) e_cnt <= 0;
      else if (e_cnt < e_delay - 1) e_cnt <= e_cnt + 1;
   end
   assign bus.eng_finish = (bus.eng_en && (e_cnt == e_delay - 1)) ||
                           (spur_en && (bus.rd_req || bus.out_we));
   assign bus.eng_psum = eng_f(bus.eng_ai, bus.eng_matrix);

   function automatic int sx16(input logic [15:0] x);
      return int'($signed(x));
   endfunction

   // Reference: per row n, per column tile j, 16-bit tile dot product, then accumulate.
   task automatic compute_ref();
      longint s;
      int acc, p;
      for (int n = 0; n < N; n++) begin
         acc = 0;
         for (int j = 0; j < T; j++) begin
            s = 0;
            for (int c = 0; c < 16; c++) s += longint'(mm[n][16*j+c]) * longint'(vv[16*j+c]);
            p = sx16(s[15:0]);
            acc = acc + p;
`ifdef MV_SCHED_SAT_ACC_EN
            if (acc > 32767) acc = 32767;
            else if (acc < -32768) acc = -32768;
`else
            acc = sx16(acc[15:0]);
`endif
         end
         expo[n] = acc[15:0];
      end
   endtask

   function automatic logic [255:0] exp_tile(input int i);
      logic [255:0] e;
      for (int k = 0; k < 16; k++) e[255-16*k -: 16] = expo[16*i+k];
      return e;
   endfunction

   function automatic int total_cycles(input int e);
      return T * T * (3 + e) + T + 1;
   endfunction

   task automatic run_product(input int edly, input bit repulse, input bit spur, input bit abort_21);
      bit prev_en;
      int off_len, k_run;
      e_delay = edly; spur_en = spur;
      wr_cnt = 0; rd_cnt = 0; done_cnt = 0; done_cyc = -1; gap_bad = 0; busy_bad = 0;
      timed_out = 1'b1; ab_post_we = 0; ab_post_done = 0; ab_post_busy = 0;
      ab_en = 1'bx; ab_busy = 1'bx; ab_we = 1'bx;
      for (int q = 0; q < T; q++) got[q] = '0;
      prev_en = 1'b0; off_len = 0; k_run = 0;
      @(negedge clk); bus.start = 1'b1;
      for (int cyc = 1; cyc <= 3000; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.rd_req) rd_cnt++;
         if (bus.out_we) begin wr_cnt++; got[bus.out_addr] = bus.out_data; end
         if (bus.done) begin done_cnt++; done_cyc = cyc; end
         if (bus.done ? bus.busy : !bus.busy) busy_bad++;
         if (bus.eng_en && !prev_en) begin
            if (k_run > 0 && off_len != ((k_run % T == 0) ? 4 : 3)) gap_bad++;
            if (abort_21 && k_run == 2 * T + 1) begin
               rst = 1'b1;
               @(negedge clk);
               ab_en = bus.eng_en; ab_busy = bus.busy; ab_we = bus.out_we;
               rst = 1'b0;
               for (int z = 0; z < 30; z++) begin
                  @(negedge clk);
                  if (bus.out_we) ab_post_we++;
                  if (bus.done) ab_post_done++;
                  if (bus.busy) ab_post_busy++;
               end
               timed_out = 1'b0;
               break;
            end
            if (repulse && k_run == 5) bus.start = 1'b1;
            k_run++;
         end
         if (!bus.eng_en) off_len++; else off_len = 0;
         prev_en = bus.eng_en;
         if (bus.done) begin timed_out = 1'b0; break; end
      end
      runs = k_run;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus.busy, bus.done, bus.rd_req, bus.eng_en, bus.out_we} !== 5'b0) begin
         tests_failed++; $display("FAIL reset_strobes got=%b exp=00000",
            {bus.busy, bus.done, bus.rd_req, bus.eng_en, bus.out_we});
      end
      tests_run++;
      if ({bus.vec_addr, bus.mat_addr, bus.out_addr} !== 8'b0) begin
         tests_failed++; $display("FAIL reset_addrs got=%h exp=00", {bus.vec_addr, bus.mat_addr, bus.out_addr});
      end
      tests_run++;
      if (bus.eng_ai !== 256'b0 || bus.out_data !== 256'b0 || bus.eng_matrix !== 4096'b0) begin
         tests_failed++; $display("FAIL reset_data ai=%h out=%h", bus.eng_ai, bus.out_data);
      end
   endtask

   task automatic test_identity();
      logic [255:0] e;
      for (int n = 0; n < N; n++) begin
         vv[n] = 16'(n);
         for (int m = 0; m < N; m++) mm[n][m] = (n == m) ? 16'sd1 : 16'sd0;
      end
      run_product(3, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (timed_out) begin tests_failed++; $display("FAIL ident_timeout got=no_done exp=done"); end
      for (int i = 0; i < T; i++) begin
         for (int k = 0; k < 16; k++) e[255-16*k -: 16] = 16'(16 * i + k);
         tests_run++;
         if (got[i] !== e) begin tests_failed++; $display("FAIL ident_tile%0d got=%h exp=%h", i, got[i], e); end
      end
      tests_run++;
      if (wr_cnt !== T || done_cnt !== 1) begin
         tests_failed++; $display("FAIL ident_counts got=%0d/%0d exp=%0d/1", wr_cnt, done_cnt, T);
      end
      tests_run++;
      if (done_cyc !== total_cycles(3)) begin
         tests_failed++; $display("FAIL ident_done_cycle got=%0d exp=%0d", done_cyc, total_cycles(3));
      end
      tests_run++;
      if (busy_bad !== 0 || gap_bad !== 0) begin
         tests_failed++; $display("FAIL ident_busy_gap got=%0d/%0d exp=0/0", busy_bad, gap_bad);
      end
   endtask

   task automatic test_all_ones();
      for (int n = 0; n < N; n++) begin
         vv[n] = 16'sd2;
         for (int m = 0; m < N; m++) mm[n][m] = 16'sd1;
      end
      run_product(2, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < T; i++) begin
         tests_run++;
         if (got[i] !== {16{16'd128}}) begin
            tests_failed++; $display("FAIL ones_tile%0d got=%h exp=%h", i, got[i], {16{16'd128}});
         end
      end
      tests_run++;
      if (timed_out || done_cyc !== total_cycles(2)) begin
         tests_failed++; $display("FAIL ones_done_cycle got=%0d exp=%0d", done_cyc, total_cycles(2));
      end
   endtask

   task automatic test_big_acc();
      logic [15:0] c;
`ifdef MV_SCHED_SAT_ACC_EN
      c = 16'd32767;
`else
      c = 16'd14464;
`endif
      for (int n = 0; n < N; n++) begin
         vv[n] = 16'sd1;
         for (int m = 0; m < N; m++) mm[n][m] = (m % 16 == 0) ? 16'sd20000 : 16'sd0;
      end
      run_product(3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < T; i++) begin
         tests_run++;
         if (got[i] !== {16{c}}) begin
            tests_failed++; $display("FAIL bigacc_tile%0d got=%h exp=%h", i, got[i], {16{c}});
         end
      end
   endtask

   task automatic random_data();
      for (int n = 0; n < N; n++) begin
         vv[n] = 16'($urandom);
         for (int m = 0; m < N; m++) mm[n][m] = 16'($urandom);
      end
      compute_ref();
   endtask

   task automatic test_repulse();
      random_data();
      run_product(3, 1'b1, 1'b0, 1'b0);
      tests_run++;
      if (wr_cnt !== T || done_cnt !== 1 || done_cyc !== total_cycles(3)) begin
         tests_failed++; $display("FAIL repulse_counts got=%0d/%0d/%0d exp=%0d/1/%0d",
            wr_cnt, done_cnt, done_cyc, T, total_cycles(3));
      end
      for (int i = 0; i < T; i++) begin
         tests_run++;
         if (got[i] !== exp_tile(i)) begin
            tests_failed++; $display("FAIL repulse_tile%0d got=%h exp=%h", i, got[i], exp_tile(i));
         end
      end
   endtask

   task automatic test_abort();
      random_data();
      run_product(4, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (ab_en !== 1'b0 || ab_busy !== 1'b0 || ab_we !== 1'b0) begin
         tests_failed++; $display("FAIL abort_next_cycle got=%b%b%b exp=000", ab_en, ab_busy, ab_we);
      end
      tests_run++;
      if (ab_post_we !== 0 || ab_post_done !== 0 || ab_post_busy !== 0 || runs !== 2 * T + 1) begin
         tests_failed++; $display("FAIL abort_quiet got=%0d/%0d/%0d runs=%0d exp=0/0/0 runs=%0d",
            ab_post_we, ab_post_done, ab_post_busy, runs, 2 * T + 1);
      end
      run_product(4, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (timed_out || wr_cnt !== T || done_cyc !== total_cycles(4)) begin
         tests_failed++; $display("FAIL abort_fresh_run got=%0d/%0d exp=%0d/%0d", wr_cnt, done_cyc, T, total_cycles(4));
      end
      for (int i = 0; i < T; i++) begin
         tests_run++;
         if (got[i] !== exp_tile(i)) begin
            tests_failed++; $display("FAIL abort_fresh_tile%0d got=%h exp=%h", i, got[i], exp_tile(i));
         end
      end
   endtask

   task automatic test_delays();
      int d;
      random_data();
      for (int r = 0; r < 2; r++) begin
         d = (r == 0) ? 1 : 20;
         run_product(d, 1'b0, 1'b0, 1'b0);
         tests_run++;
         if (timed_out || done_cyc !== total_cycles(d) || rd_cnt !== T * T || gap_bad !== 0) begin
            tests_failed++; $display("FAIL delay%0d_timing got=%0d rd=%0d gap=%0d exp=%0d rd=%0d gap=0",
               d, done_cyc, rd_cnt, gap_bad, total_cycles(d), T * T);
         end
         for (int i = 0; i < T; i++) begin
            tests_run++;
            if (got[i] !== exp_tile(i)) begin
               tests_failed++; $display("FAIL delay%0d_tile%0d got=%h exp=%h", d, i, got[i], exp_tile(i));
            end
         end
      end
   endtask

   task automatic test_random();
      int d;
      for (int it = 0; it < 3; it++) begin
         random_data();
         d = int'($urandom_range(6, 1));
         run_product(d, 1'b0, 1'b1, 1'b0);
         tests_run++;
         if (timed_out || done_cyc !== total_cycles(d) || wr_cnt !== T) begin
            tests_failed++; $display("FAIL rand%0d_timing got=%0d wr=%0d exp=%0d wr=%0d",
               it, done_cyc, wr_cnt, total_cycles(d), T);
         end
         for (int i = 0; i < T; i++) begin
            tests_run++;
            if (got[i] !== exp_tile(i)) begin
               tests_failed++; $display("FAIL rand%0d_tile%0d got=%h exp=%h", it, i, got[i], exp_tile(i));
            end
         end
      end
   endtask

   initial begin
      bus.start = 1'b0;
      rst = 1'b1;
      test_reset();
      test_identity();
      test_all_ones();
      test_big_acc();
      test_repulse();
      test_abort();
      test_delays();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
